// File: rtl/pdm_mic_pkg.sv
// Shared types, default parameters and helpers for the PDM microphone front end.
package pdm_mic_pkg;

    localparam int unsigned CLK_DIV_DEF  = 24;
    localparam int unsigned NCH_DEF      = 4;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned WAKE_PER_DEF = 16384;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Bits needed to index v distinct values; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock divider, wake-up sequencer and per-period stereo bit capture.
module pdm_clkgen
    import pdm_mic_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned WAKE_PER = WAKE_PER_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NCH/2-1:0]   pdm_dat,
    output logic               pdm_clk,
    output logic               bit_dv,
    output logic [NCH-1:0]     bit_o,
    output logic               running
);

    localparam int unsigned CW = clog2(CLK_DIV);
    localparam int unsigned PW = clog2(WAKE_PER);
    localparam int unsigned NL = NCH / 2;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    per_q, per_d;
    logic [NL-1:0]    even_q, even_d;
    logic [NCH-1:0]   bit_q, bit_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic             bit_dv_q, bit_dv_d;
    logic             running_q, running_d;
    logic             last_hi, last_lo;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        even_d    = even_q;
        bit_d     = bit_q;
        bit_dv_d  = 1'b0;
        last_hi   = (cnt_q == CW'(CLK_DIV / 2 - 1));
        last_lo   = (cnt_q == CW'(CLK_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                per_d = '0;
                if (enable) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (last_lo) begin
                    per_d = per_q + 1'b1;
                    if (per_q == PW'(WAKE_PER - 1)) begin
                        state_d = ST_RUN;
                        per_d   = '0;
                    end
                end
            end
            ST_RUN:  ;
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE) begin
            cnt_d = last_lo ? '0 : cnt_q + 1'b1;
            if (last_hi) even_d = pdm_dat;
        end

        // Left mic drives the line while the clock is high, right mic while low.
        if (state_q == ST_RUN && last_lo && enable) begin
            bit_dv_d = 1'b1;
            for (int unsigned j = 0; j < NL; j++) begin
                bit_d[2*j]   = even_q[j];
                bit_d[2*j+1] = pdm_dat[j];
            end
        end

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            per_d   = '0;
        end

        pdm_clk_d = (state_d != ST_IDLE) && (cnt_d < CW'(CLK_DIV / 2));
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            even_q    <= '0;
            bit_q     <= '0;
            pdm_clk_q <= 1'b0;
            bit_dv_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            even_q    <= even_d;
            bit_q     <= bit_d;
            pdm_clk_q <= pdm_clk_d;
            bit_dv_q  <= bit_dv_d;
            running_q <= running_d;
        end
    end

    assign pdm_clk = pdm_clk_q;
    assign bit_dv  = bit_dv_q;
    assign bit_o   = bit_q;
    assign running = running_q;

endmodule

// File: rtl/pdm_mic_scheduler.sv
// PDM mic array front end: clock/capture sub-block plus round-robin merge of
// decimated channel samples onto one ready/valid stream.
module pdm_mic_scheduler
    import pdm_mic_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned WAKE_PER = WAKE_PER_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   pdm_clk,
    input  logic [NCH/2-1:0]       pdm_dat,
    output logic                   bit_dv,
    output logic [NCH-1:0]         bit_o,
    input  logic [NCH-1:0]         samp_dv,
    input  logic [NCH*DW-1:0]      samp_i,
    output logic                   out_dv,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_dat,
    output logic [clog2(NCH)-1:0]  out_ch,
    output logic                   running,
    output logic [NCH-1:0]         overrun,
    input  logic                   ovr_clr
);

    localparam int unsigned CHW = clog2(NCH);

    logic [NCH-1:0][DW-1:0] hold_q, hold_d;
    logic [NCH-1:0]         pend_q, pend_d;
    logic [NCH-1:0]         ovr_q, ovr_d;
    logic [NCH-1:0]         gnt_oh;
    logic [CHW-1:0]         ptr_q, ptr_d;
    logic [CHW-1:0]         gnt, idx;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic [DW-1:0]          out_dat_q, out_dat_d;
    logic                   out_dv_q, out_dv_d;
    logic                   found, slot_free;

    pdm_clkgen #(
        .CLK_DIV  (CLK_DIV),
        .NCH      (NCH),
        .WAKE_PER (WAKE_PER)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .pdm_dat (pdm_dat),
        .pdm_clk (pdm_clk),
        .bit_dv  (bit_dv),
        .bit_o   (bit_o),
        .running (running)
    );

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = CHW'((32'(ptr_q) + i) % NCH);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        slot_free = !out_dv_q || out_ready;
        gnt_oh    = '0;
        out_dv_d  = out_dv_q;
        out_dat_d = out_dat_q;
        out_ch_d  = out_ch_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        if (slot_free) begin
            out_dv_d = found;
            if (found) begin
                gnt_oh[gnt] = 1'b1;
                out_dat_d   = hold_q[gnt];
                out_ch_d    = gnt;
                ptr_d       = (gnt == CHW'(NCH - 1)) ? '0 : gnt + 1'b1;
            end
        end

        for (int unsigned k = 0; k < NCH; k++) begin
            if (samp_dv[k]) hold_d[k] = samp_i[k*DW +: DW];
        end

        // A sample landing on an ungranted pending slot replaces it and is flagged.
        pend_d = samp_dv | (pend_q & ~gnt_oh);
        ovr_d  = (ovr_clr ? '0 : ovr_q) | (samp_dv & pend_q & ~gnt_oh);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
            ptr_q     <= '0;
            out_dv_q  <= 1'b0;
            out_dat_q <= '0;
            out_ch_q  <= '0;
        end else begin
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            ptr_q     <= ptr_d;
            out_dv_q  <= out_dv_d;
            out_dat_q <= out_dat_d;
            out_ch_q  <= out_ch_d;
        end
    end

    assign out_dv  = out_dv_q;
    assign out_dat = out_dat_q;
    assign out_ch  = out_ch_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_pdm_mic_scheduler.sv
// Scoreboard bench for pdm_mic_scheduler with a period/phase reference model.
module tb_pdm_mic_scheduler;

    localparam int CLK_DIV  = 4;
    localparam int NCH      = 4;
    localparam int DW       = 16;
    localparam int WAKE_PER = 3;
    localparam int HALF     = CLK_DIV / 2;
    localparam int NL       = NCH / 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              pdm_clk;
    logic [NL-1:0]     pdm_dat = '0;
    logic              bit_dv;
    logic [NCH-1:0]    bit_o;
    logic [NCH-1:0]    samp_dv = '0;
    logic [NCH*DW-1:0] samp_i = '0;
    logic              out_dv;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_dat;
    logic [1:0]        out_ch;
    logic              running;
    logic [NCH-1:0]    overrun;
    logic              ovr_clr = 1'b0;

    always #5 clk = ~clk;

    pdm_mic_scheduler #(
        .CLK_DIV  (CLK_DIV),
        .NCH      (NCH),
        .DW       (DW),
        .WAKE_PER (WAKE_PER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pdm_clk   (pdm_clk),
        .pdm_dat   (pdm_dat),
        .bit_dv    (bit_dv),
        .bit_o     (bit_o),
        .samp_dv   (samp_dv),
        .samp_i    (samp_i),
        .out_dv    (out_dv),
        .out_ready (out_ready),
        .out_dat   (out_dat),
        .out_ch    (out_ch),
        .running   (running),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    typedef struct { logic [NCH-1:0] bits; int due; } bit_exp_t;
    typedef struct { int ch; logic [DW-1:0] dat; } smp_exp_t;

    bit_exp_t bq[$];
    smp_exp_t sq[$];

    int n_chk = 0, n_pass = 0, cyc = 0, k_on = 0;
    bit chk_en = 0, pat_mode = 0;
    logic e_clk = 1'b0, e_run = 1'b0;
    logic [NL-1:0] ev_line = '0;

    // Sample-path reference: latest-value mailbox per channel, rotating search.
    bit             m_outv, n_outv;
    int             m_ptr, n_ptr;
    bit             m_pend[NCH], n_pend[NCH];
    logic [DW-1:0]  m_val[NCH], n_val[NCH];
    logic [NCH-1:0] m_ovr, n_ovr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_clear();
        m_outv = 0; n_outv = 0; m_ptr = 0; n_ptr = 0; m_ovr = '0; n_ovr = '0;
        for (int k = 0; k < NCH; k++) begin
            m_pend[k] = 0; n_pend[k] = 0; m_val[k] = '0; n_val[k] = '0;
        end
    endtask

    always @(negedge clk) begin : monitor
        smp_exp_t e;
        if (chk_en) begin
            chk("pdm_clk", pdm_clk, e_clk);
            chk("running", running, e_run);
            if (bq.size() > 0 && bq[0].due == cyc) begin
                chk("bit_dv", bit_dv, 1);
                chk("bit_o", bit_o, bq[0].bits);
                void'(bq.pop_front());
            end else begin
                chk("bit_dv_quiet", bit_dv, 0);
            end
            chk("out_dv", out_dv, m_outv);
            chk("overrun", overrun, m_ovr);
            if (out_dv && out_ready) begin
                if (sq.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: ch=%0d dat=%0h, none expected (cycle %0d)", out_ch, out_dat, cyc);
                end else begin
                    e = sq.pop_front();
                    chk("out_ch", out_ch, e.ch);
                    chk("out_dat", out_dat, e.dat);
                end
            end
        end
    end

    // One clock cycle: apply inputs and advance the reference model across the next edge.
    task automatic cycle(input bit en, input logic [NCH-1:0] dv, input logic [NCH*DW-1:0] dat,
                         input bit rdy, input bit clr);
        int t, ph, per, g;
        logic [NCH-1:0] bits;
        bit_exp_t be;
        @(posedge clk); #1;
        cyc++;
        m_outv = n_outv; m_ptr = n_ptr; m_ovr = n_ovr;
        m_pend = n_pend; m_val = n_val;

        ph = -1; per = 0;
        if (k_on == 0) begin
            e_clk = 1'b0; e_run = 1'b0;
        end else begin
            t = k_on - 1; ph = t % CLK_DIV; per = t / CLK_DIV;
            e_clk = (ph < HALF); e_run = (per >= WAKE_PER);
        end
        pdm_dat = pat_mode ? (e_clk ? 2'b01 : 2'b10) : NL'($urandom);
        if (ph == HALF - 1) ev_line = pdm_dat;
        if (ph == CLK_DIV - 1 && per >= WAKE_PER && en) begin
            for (int j = 0; j < NL; j++) begin
                bits[2*j]   = ev_line[j];
                bits[2*j+1] = pdm_dat[j];
            end
            be.bits = bits; be.due = cyc + 1;
            bq.push_back(be);
        end
        k_on = en ? k_on + 1 : 0;

        enable = en; samp_dv = dv; samp_i = dat; out_ready = rdy; ovr_clr = clr;

        g = -1;
        n_outv = m_outv; n_ptr = m_ptr;
        if (!m_outv || rdy) begin
            for (int i = 0; i < NCH; i++)
                if (g < 0 && m_pend[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
            n_outv = (g >= 0);
            if (g >= 0) begin
                n_ptr = (g + 1) % NCH;
                sq.push_back('{ch: g, dat: m_val[g]});
            end
        end
        n_ovr = clr ? '0 : m_ovr;
        for (int k = 0; k < NCH; k++) begin
            if (dv[k]) begin
                if (m_pend[k] && g != k) n_ovr[k] = 1'b1;
                n_val[k]  = dat[k*DW +: DW];
                n_pend[k] = 1;
            end else begin
                n_val[k]  = m_val[k];
                n_pend[k] = m_pend[k] && (g != k);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b0; chk_en = 0;
        #1;
        chk("rst_pdm_clk", pdm_clk, 0);
        chk("rst_bit_dv", bit_dv, 0);
        chk("rst_bit_o", bit_o, 0);
        chk("rst_out_dv", out_dv, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_running", running, 0);
        chk("rst_overrun", overrun, 0);
        enable = 0; samp_dv = '0; out_ready = 0; ovr_clr = 0;
        model_clear(); bq.delete(); sq.delete();
        k_on = 0; e_clk = 0; e_run = 0;
        @(posedge clk); #1;
        reset = 1'b1; cyc++; chk_en = 1;
    endtask

    function automatic logic [NCH*DW-1:0] rnd_dat();
        return {$urandom, $urandom};
    endfunction

    initial begin
        model_clear();
        do_reset();
        repeat (3) cycle(0, '0, '0, 1, 0);

        // Wake then run with a fixed left/right pattern on the data lines.
        pat_mode = 1;
        repeat (26) cycle(1, '0, '0, 1, 0);

        // Simultaneous burst on all channels drains in channel order.
        cycle(1, 4'hF, {16'd400, 16'd300, 16'd200, 16'd100}, 1, 0);
        repeat (6) cycle(1, '0, '0, 1, 0);

        // Stall the output, double-write ch2, then clear racing a new overrun.
        cycle(1, 4'b0001, rnd_dat(), 0, 0);
        repeat (2) cycle(1, '0, '0, 0, 0);
        cycle(1, 4'b0100, rnd_dat(), 0, 0);
        cycle(1, '0, '0, 0, 0);
        cycle(1, 4'b0100, rnd_dat(), 0, 0);
        cycle(1, '0, '0, 0, 0);
        cycle(1, 4'b0100, rnd_dat(), 0, 1);
        repeat (4) cycle(1, '0, '0, 1, 0);
        cycle(1, '0, '0, 1, 1);
        repeat (2) cycle(1, '0, '0, 1, 0);

        // Back-to-back writes to one channel hit the grant cycle.
        repeat (3) cycle(1, 4'b0010, rnd_dat(), 1, 0);
        repeat (3) cycle(1, '0, '0, 1, 0);

        // Drop enable mid-period, then repeat the full wake.
        pat_mode = 0;
        cycle(1, '0, '0, 1, 0);
        repeat (2) cycle(0, '0, '0, 1, 0);
        repeat (24) cycle(1, '0, '0, 1, 0);

        // Randomised traffic, backpressure, clears and occasional enable drops.
        for (int n = 0; n < 500; n++) begin
            cycle(($urandom_range(0, 99) < 97),
                  NCH'($urandom) & NCH'($urandom),
                  rnd_dat(),
                  ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 3));
        end

        // Asynchronous reset with a stalled output and pending channels.
        repeat (2) cycle(0, 4'hF, rnd_dat(), 0, 0);
        cycle(0, '0, '0, 0, 0);
        do_reset();
        repeat (4) cycle(0, '0, '0, 1, 0);
        cycle(0, 4'b1000, rnd_dat(), 1, 0);
        repeat (4) cycle(0, '0, '0, 1, 0);

        chk("bitq_drained", bq.size(), 0);
        chk("sampq_drained", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
